// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and the pixel colour type.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;

   localparam int unsigned DEF_H_TOTAL =
      DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned DEF_V_TOTAL =
      DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   // 2 bits per channel: {r[1:0], g[1:0], b[1:0]}
   typedef logic [5:0] rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter plus sync-window and visible-region decode.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned TOTAL      = 800,
   parameter int unsigned SYNC_START = 656,
   parameter int unsigned SYNC_LEN   = 96,
   parameter int unsigned VISIBLE    = 640
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   output logic               wrap,
   output logic [COORD_W-1:0] count,
   output logic               in_sync,
   output logic               in_visible
);

   localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] SYNC_LO = COORD_W'(SYNC_START);
   localparam logic [COORD_W-1:0] VIS_END = COORD_W'(VISIBLE);
   // One extra bit so a sync window ending exactly at 1024 still decodes
   localparam logic [COORD_W:0]   SYNC_HI = (COORD_W + 1)'(SYNC_START + SYNC_LEN);

   logic [COORD_W-1:0] count_q;

   // Position register: advance on enable, return to 0 after the last position
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (enable) begin
         if (count_q == LAST) count_q <= '0;
         else                 count_q <= count_q + 1'b1;
      end
   end

   // Decode from the current position; wrap means "at terminal count", not gated by enable
   always_comb begin
      wrap       = (count_q == LAST);
      in_sync    = (count_q >= SYNC_LO) && ({1'b0, count_q} < SYNC_HI);
      in_visible = (count_q < VIS_END);
   end

   assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel divider, h/v scan counters, pin-aligned sync/rgb registers, frame strobe.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned CLK_DIV   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [COORD_W-1:0] row,
   output logic [COORD_W-1:0] col,
   output logic               visible,
   input  rgb_t               rgb_in,
   output logic               pixel_tick,
   output logic               hsync,
   output logic               vsync,
   output rgb_t               rgb_out,
   output logic               frame_start,
   output logic [15:0]        frame_count
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic             h_wrap, h_sync, h_vis;
   logic             v_wrap, v_sync, v_vis;
   logic             hsync_q, vsync_q, frame_start_q;
   rgb_t             rgb_q;
   logic [15:0]      frame_count_q;

   // Pixel-clock divider; with CLK_DIV==1 it stays at 0 and every cycle ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          div_q <= '0;
      else if (pixel_tick) div_q <= '0;
      else                 div_q <= div_q + 1'b1;
   end

   assign pixel_tick = (div_q == DIV_LAST);

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .SYNC_START (H_VISIBLE + H_FRONT),
      .SYNC_LEN   (H_SYNC),
      .VISIBLE    (H_VISIBLE)
   ) u_h (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (pixel_tick),
      .wrap       (h_wrap),
      .count      (col),
      .in_sync    (h_sync),
      .in_visible (h_vis)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .SYNC_START (V_VISIBLE + V_FRONT),
      .SYNC_LEN   (V_SYNC),
      .VISIBLE    (V_VISIBLE)
   ) u_v (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (pixel_tick && h_wrap),
      .wrap       (v_wrap),
      .count      (row),
      .in_sync    (v_sync),
      .in_visible (v_vis)
   );

   assign visible = h_vis && v_vis;

   // Pin stage: sampled from the pre-update position so sync and colour leave together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= '0;
      end else if (pixel_tick) begin
         hsync_q <= !h_sync;
         vsync_q <= !v_sync;
         rgb_q   <= visible ? rgb_in : '0;
      end
   end

   // Frame strobe and counter: both update on the tick that leaves the last pixel of the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         frame_start_q <= pixel_tick && h_wrap && v_wrap;
         if (pixel_tick && h_wrap && v_wrap) frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb_out     = rgb_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 640x480 geometry, a 14x9 small geometry, and CLK_DIV=4.
module tb_vga_timing;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] rgb_in = 6'h00;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Default geometry
   logic [9:0]  d_row, d_col;
   logic        d_vis, d_tick, d_hs, d_vs, d_fs;
   logic [5:0]  d_rgb;
   logic [15:0] d_fc;

   vga_timing u_def (
      .clk         (clk),
      .rst_n       (rst_n),
      .row         (d_row),
      .col         (d_col),
      .visible     (d_vis),
      .rgb_in      (rgb_in),
      .pixel_tick  (d_tick),
      .hsync       (d_hs),
      .vsync       (d_vs),
      .rgb_out     (d_rgb),
      .frame_start (d_fs),
      .frame_count (d_fc)
   );

   // Small geometry: H 8/2/2/2 (14), V 6/1/1/1 (9)
   logic [9:0]  s_row, s_col;
   logic        s_vis, s_tick, s_hs, s_vs, s_fs;
   logic [5:0]  s_rgb;
   logic [15:0] s_fc;

   vga_timing #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
      .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
   ) u_small (
      .clk         (clk),
      .rst_n       (rst_n),
      .row         (s_row),
      .col         (s_col),
      .visible     (s_vis),
      .rgb_in      (rgb_in),
      .pixel_tick  (s_tick),
      .hsync       (s_hs),
      .vsync       (s_vs),
      .rgb_out     (s_rgb),
      .frame_start (s_fs),
      .frame_count (s_fc)
   );

   // Small geometry with a divide-by-4 pixel clock
   logic [9:0]  q_row, q_col;
   logic        q_vis, q_tick, q_hs, q_vs, q_fs;
   logic [5:0]  q_rgb;
   logic [15:0] q_fc;

   vga_timing #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
      .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .CLK_DIV   (4)
   ) u_div4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .row         (q_row),
      .col         (q_col),
      .visible     (q_vis),
      .rgb_in      (rgb_in),
      .pixel_tick  (q_tick),
      .hsync       (q_hs),
      .vsync       (q_vs),
      .rgb_out     (q_rgb),
      .frame_start (q_fs),
      .frame_count (q_fc)
   );

   typedef struct packed {
      int          adv;
      logic [5:0]  rgb;
      logic [9:0]  row;
      logic [9:0]  col;
      logic        hs;
      logic        vs;
      logic [5:0]  rgbo;
      logic        fs;
      logic [15:0] fc;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(input int adv, input logic [5:0] rgb, input int r, input int c,
                               input logic hs, input logic vs, input logic [5:0] rgbo,
                               input logic fs, input int fc);
      vec_t v;
      v.adv  = adv;
      v.rgb  = rgb;
      v.row  = 10'(r);
      v.col  = 10'(c);
      v.hs   = hs;
      v.vs   = vs;
      v.rgbo = rgbo;
      v.fs   = fs;
      v.fc   = 16'(fc);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int first_low;
      int low_cnt;
      int fs_cnt;
      int p, r, c, t;
      logic [5:0] exp_rgb;

      // Small geometry, cumulative tick count k noted per line: pins show position k-1
      vecs[0]  = mk(1,   6'h3F, 0, 1,  1, 1, 6'h3F, 0, 0); // k=1
      vecs[1]  = mk(7,   6'h3F, 0, 8,  1, 1, 6'h3F, 0, 0); // k=8, last visible col
      vecs[2]  = mk(1,   6'h3F, 0, 9,  1, 1, 6'h00, 0, 0); // k=9, front porch blanked
      vecs[3]  = mk(2,   6'h3F, 0, 11, 0, 1, 6'h00, 0, 0); // k=11, hsync from col 10
      vecs[4]  = mk(1,   6'h3F, 0, 12, 0, 1, 6'h00, 0, 0); // k=12
      vecs[5]  = mk(1,   6'h3F, 0, 13, 1, 1, 6'h00, 0, 0); // k=13, hsync released
      vecs[6]  = mk(1,   6'h3F, 1, 0,  1, 1, 6'h00, 0, 0); // k=14, line wrap
      vecs[7]  = mk(1,   6'h2A, 1, 1,  1, 1, 6'h2A, 0, 0); // k=15
      vecs[8]  = mk(83,  6'h3F, 7, 0,  1, 1, 6'h00, 0, 0); // k=98
      vecs[9]  = mk(1,   6'h3F, 7, 1,  1, 0, 6'h00, 0, 0); // k=99, vsync starts
      vecs[10] = mk(10,  6'h3F, 7, 11, 0, 0, 6'h00, 0, 0); // k=109, both syncs low
      vecs[11] = mk(3,   6'h3F, 8, 0,  1, 0, 6'h00, 0, 0); // k=112
      vecs[12] = mk(1,   6'h3F, 8, 1,  1, 1, 6'h00, 0, 0); // k=113, vsync released
      vecs[13] = mk(12,  6'h3F, 8, 13, 1, 1, 6'h00, 0, 0); // k=125, no strobe yet
      vecs[14] = mk(1,   6'h3F, 0, 0,  1, 1, 6'h00, 1, 1); // k=126, frame wrap
      vecs[15] = mk(1,   6'h3F, 0, 1,  1, 1, 6'h3F, 0, 1); // k=127
      vecs[16] = mk(251, 6'h3F, 0, 0,  1, 1, 6'h00, 1, 3); // k=378
      vecs[17] = mk(1,   6'h3F, 0, 1,  1, 1, 6'h3F, 0, 3); // k=379

      // Reset held for 5 clocks
      rgb_in = 6'h3F;
      repeat (5) @(negedge clk);
      chk("rst.row", 32'(d_row), 0);
      chk("rst.col", 32'(d_col), 0);
      chk("rst.hsync", 32'(d_hs), 1);
      chk("rst.vsync", 32'(d_vs), 1);
      chk("rst.rgb_out", 32'(d_rgb), 0);
      chk("rst.frame_start", 32'(d_fs), 0);
      chk("rst.frame_count", 32'(d_fc), 0);

      // Default line timing over 800 ticks
      rst_n = 1'b1;
      first_low = -1;
      low_cnt = 0;
      for (int k = 1; k <= 800; k++) begin
         @(negedge clk);
         if (d_hs == 1'b0) begin
            low_cnt++;
            if (first_low < 0) first_low = k;
         end
      end
      chk("line.col", 32'(d_col), 0);
      chk("line.row", 32'(d_row), 1);
      chk("line.hsync_low_ticks", 32'(low_cnt), 96);
      chk("line.first_low_tick", 32'(first_low), 657);
      chk("line.vsync", 32'(d_vs), 1);
      chk("line.frame_count", 32'(d_fc), 0);

      // Table-driven small geometry
      do_reset();
      for (int i = 0; i < 18; i++) begin
         rgb_in = vecs[i].rgb;
         repeat (vecs[i].adv) @(negedge clk);
         chk($sformatf("vec%0d.row", i), 32'(s_row), 32'(vecs[i].row));
         chk($sformatf("vec%0d.col", i), 32'(s_col), 32'(vecs[i].col));
         chk($sformatf("vec%0d.hsync", i), 32'(s_hs), 32'(vecs[i].hs));
         chk($sformatf("vec%0d.vsync", i), 32'(s_vs), 32'(vecs[i].vs));
         chk($sformatf("vec%0d.rgb_out", i), 32'(s_rgb), 32'(vecs[i].rgbo));
         chk($sformatf("vec%0d.frame_start", i), 32'(s_fs), 32'(vecs[i].fs));
         chk($sformatf("vec%0d.frame_count", i), 32'(s_fc), 32'(vecs[i].fc));
      end

      // Reset mid-frame at (row 4, col 5) of the fourth frame
      rgb_in = 6'h3F;
      repeat (60) @(negedge clk);
      chk("mid.pre_row", 32'(s_row), 4);
      chk("mid.pre_col", 32'(s_col), 5);
      chk("mid.pre_rgb_out", 32'(s_rgb), 32'h3F);
      chk("mid.pre_frame_count", 32'(s_fc), 3);
      rst_n = 1'b0;
      #1;
      chk("mid.row", 32'(s_row), 0);
      chk("mid.col", 32'(s_col), 0);
      chk("mid.hsync", 32'(s_hs), 1);
      chk("mid.vsync", 32'(s_vs), 1);
      chk("mid.rgb_out", 32'(s_rgb), 0);
      chk("mid.frame_start", 32'(s_fs), 0);
      chk("mid.frame_count", 32'(s_fc), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid.resume_row", 32'(s_row), 0);
      chk("mid.resume_col", 32'(s_col), 1);
      chk("mid.resume_frame_count", 32'(s_fc), 0);

      // Three frames with constant white input: blanking, syncs and strobe cadence
      do_reset();
      rgb_in = 6'h3F;
      fs_cnt = 0;
      for (int k = 1; k <= 378; k++) begin
         @(negedge clk);
         p = (k - 1) % 126;
         r = p / 14;
         c = p % 14;
         exp_rgb = (r < 6 && c < 8) ? 6'h3F : 6'h00;
         chk($sformatf("sweep%0d.rgb_out", k), 32'(s_rgb), 32'(exp_rgb));
         chk($sformatf("sweep%0d.hsync", k), 32'(s_hs), (c >= 10 && c < 12) ? 0 : 1);
         chk($sformatf("sweep%0d.vsync", k), 32'(s_vs), (r == 7) ? 0 : 1);
         if (s_fs) fs_cnt++;
      end
      chk("sweep.frame_starts", 32'(fs_cnt), 3);
      chk("sweep.frame_count", 32'(s_fc), 3);

      // CLK_DIV=4: tick cadence; rgb_in is 0x3F except on the cycle that ticks
      do_reset();
      for (int n = 0; n <= 40; n++) begin
         if (n > 0) @(negedge clk);
         t = n / 4;
         chk($sformatf("div%0d.pixel_tick", n), 32'(q_tick), (n % 4 == 3) ? 1 : 0);
         chk($sformatf("div%0d.col", n), 32'(q_col), 32'(t));
         exp_rgb = (t == 0) ? 6'h00 : ((t - 1 < 8) ? 6'h15 : 6'h00);
         chk($sformatf("div%0d.rgb_out", n), 32'(q_rgb), 32'(exp_rgb));
         rgb_in = (n % 4 == 3) ? 6'h15 : 6'h3F;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
